video_timing_gen: RTL and testbench

Parametrised raster timing generator for the HDMI/DVI transmit path, driven from the pixel clock ahead of the three TMDS encoders. It replaces fixed full-frame counters with a configurable active/front-porch/sync/back-porch raster per axis, programmable sync polarity, and registered pixel coordinates, plus frame and line strobes. An optional colour-bar source provides a self-contained display test.

---
 rtl/video_timing_gen.sv | 114 +++++++++++
 tb/tb_video_timing_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: configurable porch/sync per axis, registered coordinates and strobes.
// Define VTG_PATTERN_EN to add an 8-bar colour test pattern on rgb; otherwise rgb is tied to 0.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE = 1920,
   parameter int unsigned H_FP     = 88,
   parameter int unsigned H_SYNC   = 44,
   parameter int unsigned H_BP     = 148,
   parameter int unsigned V_ACTIVE = 1080,
   parameter int unsigned V_FP     = 4,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 36,
   parameter bit          H_POL    = 1'b1,
   parameter bit          V_POL    = 1'b1,
   parameter int unsigned CW       = 12
) (
   input  logic          pixclk,
   input  logic          reset,
   input  logic          en,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [23:0]   rgb
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = VS_BEG + V_SYNC;

   logic [CW-1:0] hcnt, vcnt;
   logic [31:0]   hc, vc;
   logic          h_last, v_last, active, hs_on, vs_on, run;

   // Wide copies keep every comparison at 32 bits, so totals up to 2^CW compare cleanly.
   always_comb begin
      hc     = 32'(hcnt);
      vc     = 32'(vcnt);
      h_last = (hc == H_TOTAL - 1);
      v_last = (vc == V_TOTAL - 1);
      active = (hc < H_ACTIVE) && (vc < V_ACTIVE);
      hs_on  = (hc >= HS_BEG) && (hc < HS_END);
      vs_on  = (vc >= VS_BEG) && (vc < VS_END);
      run    = !reset && en;
   end

   always_ff @(posedge pixclk) begin
      if (!run) begin
         hcnt        <= '0;
         vcnt        <= '0;
         de          <= 1'b0;
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hcnt <= h_last ? '0 : hcnt + 1'b1;
         if (h_last)
            vcnt <= v_last ? '0 : vcnt + 1'b1;
         de          <= active;
         hsync       <= hs_on ? H_POL : ~H_POL;
         vsync       <= vs_on ? V_POL : ~V_POL;
         x           <= active ? hcnt : '0;
         y           <= active ? vcnt : '0;
         line_start  <= (hcnt == '0);
         frame_start <= (hcnt == '0) && (vcnt == '0);
      end
   end

`ifdef VTG_PATTERN_EN
   localparam int unsigned BW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [CW-1:0] bar_pix;
   logic [2:0]    bar_idx;
   logic [23:0]   bar_rgb;

   // bar_pix/bar_idx track the current hcnt; index saturates at 7 so remainder pixels stay black.
   always_ff @(posedge pixclk) begin
      if (!run || h_last) begin
         bar_pix <= '0;
         bar_idx <= '0;
      end else if (32'(bar_pix) == BW - 1) begin
         bar_pix <= '0;
         if (bar_idx != 3'd7)
            bar_idx <= bar_idx + 3'd1;
      end else begin
         bar_pix <= bar_pix + 1'b1;
      end
   end

   always_comb begin
      bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
   end

   always_ff @(posedge pixclk) begin
      if (!run)
         rgb <= '0;
      else
         rgb <= active ? bar_rgb : '0;
   end
`else
   always_comb begin
      rgb = '0;
   end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 16x8 raster, one instance per sync polarity.
// Expected outputs come from a raster-position model (cycles since frame start).
module tb_video_timing_gen;

   logic        pixclk = 1'b0;
   logic        reset  = 1'b1;
   logic        en     = 1'b0;

   logic        de_p, hs_p, vs_p, ls_p, fs_p;
   logic [3:0]  x_p, y_p;
   logic [23:0] rgb_p;
   logic        de_n, hs_n, vs_n, ls_n, fs_n;
   logic [3:0]  x_n, y_n;
   logic [23:0] rgb_n;

   int unsigned pass_cnt = 0;
   int unsigned tot_cnt  = 0;
   int unsigned cyc      = 0;
   int unsigned pos      = 0;
   logic [36:0] exp_p, exp_n, obs_p, obs_n;

   always #5 pixclk = ~pixclk;

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .CW(4)
   ) dut_p (
      .pixclk(pixclk), .reset(reset), .en(en),
      .de(de_p), .hsync(hs_p), .vsync(vs_p), .x(x_p), .y(y_p),
      .line_start(ls_p), .frame_start(fs_p), .rgb(rgb_p)
   );

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .CW(4)
   ) dut_n (
      .pixclk(pixclk), .reset(reset), .en(en),
      .de(de_n), .hsync(hs_n), .vsync(vs_n), .x(x_n), .y(y_n),
      .line_start(ls_n), .frame_start(fs_n), .rgb(rgb_n)
   );

   assign obs_p = {de_p, hs_p, vs_p, x_p, y_p, ls_p, fs_p, rgb_p};
   assign obs_n = {de_n, hs_n, vs_n, x_n, y_n, ls_n, fs_n, rgb_n};

   function automatic logic [23:0] bar_color(input int unsigned col);
`ifdef VTG_PATTERN_EN
      case (col)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
`else
      return 24'h000000;
`endif
   endfunction

   // p = cycles since frame start of the counter state decoded on this edge.
   function automatic logic [36:0] model(input bit running, input int unsigned p,
                                         input bit hpol, input bit vpol);
      int unsigned h, v;
      bit act, hs, vs;
      if (!running)
         return {1'b0, ~hpol, ~vpol, 4'd0, 4'd0, 1'b0, 1'b0, 24'd0};
      h   = p % 16;
      v   = p / 16;
      act = (h < 8) && (v < 4);
      hs  = (h >= 10) && (h < 13);
      vs  = (v >= 5) && (v < 7);
      return {act, hs ? hpol : ~hpol, vs ? vpol : ~vpol,
              act ? 4'(h) : 4'd0, act ? 4'(v) : 4'd0,
              h == 0, p == 0, act ? bar_color(h) : 24'd0};
   endfunction

   task automatic step(input bit r, input bit e);
      bit running;
      int unsigned cur;
      reset = r;
      en    = e;
      @(posedge pixclk);
      #1;
      cyc++;
      running = !r && e;
      cur     = pos;
      pos     = running ? (pos + 1) % 128 : 0;
      exp_p   = model(running, cur, 1'b1, 1'b1);
      exp_n   = model(running, cur, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, i[0]);
         tot_cnt++;
         if (obs_p !== exp_p) $display("FAIL reset_p: got %h want %h", obs_p, exp_p);
         else pass_cnt++;
         tot_cnt++;
         if ({hs_p, vs_p, hs_n, vs_n} !== 4'b0011)
            $display("FAIL reset_sync: got %b want 0011", {hs_p, vs_p, hs_n, vs_n});
         else pass_cnt++;
      end
      step(1'b0, 1'b1);
      tot_cnt++;
      if ({de_p, x_p, y_p, fs_p, ls_p} !== {1'b1, 4'd0, 4'd0, 1'b1, 1'b1})
         $display("FAIL first_edge: got %b want %b", {de_p, x_p, y_p, fs_p, ls_p},
                  {1'b1, 4'd0, 4'd0, 1'b1, 1'b1});
      else pass_cnt++;
   endtask

   task automatic test_frames;
      int last_fs = -1;
      int last_ls = -1;
      int unsigned de_cnt = 0;
      int unsigned vs_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b0, 1'b1);
         tot_cnt++;
         if (obs_p !== exp_p) $display("FAIL frames_p cyc %0d: got %h want %h", cyc, obs_p, exp_p);
         else pass_cnt++;
         tot_cnt++;
         if (obs_n !== exp_n) $display("FAIL frames_n cyc %0d: got %h want %h", cyc, obs_n, exp_n);
         else pass_cnt++;
         if (de_p) de_cnt++;
         if (vs_p) vs_cnt++;
         if (fs_p) begin
            if (last_fs >= 0) begin
               tot_cnt++;
               if (int'(cyc) - last_fs != 128)
                  $display("FAIL frame_period: got %0d want 128", int'(cyc) - last_fs);
               else pass_cnt++;
            end
            last_fs = int'(cyc);
         end
         if (ls_p) begin
            if (last_ls >= 0) begin
               tot_cnt++;
               if (int'(cyc) - last_ls != 16)
                  $display("FAIL line_period: got %0d want 16", int'(cyc) - last_ls);
               else pass_cnt++;
            end
            last_ls = int'(cyc);
         end
      end
      tot_cnt++;
      if (de_cnt != 64) $display("FAIL de_count: got %0d want 64", de_cnt);
      else pass_cnt++;
      tot_cnt++;
      if (vs_cnt != 64) $display("FAIL vsync_count: got %0d want 64", vs_cnt);
      else pass_cnt++;
   endtask

   task automatic test_en_drop;
      for (int i = 0; i < 128 && pos != 37; i++)
         step(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         tot_cnt++;
         if (obs_p !== exp_p) $display("FAIL en_low_p: got %h want %h", obs_p, exp_p);
         else pass_cnt++;
         tot_cnt++;
         if ({de_p, hs_p, vs_p, hs_n, vs_n, ls_p, fs_p} !== 7'b0001100)
            $display("FAIL en_low_flags: got %b want 0001100",
                     {de_p, hs_p, vs_p, hs_n, vs_n, ls_p, fs_p});
         else pass_cnt++;
      end
      step(1'b0, 1'b1);
      tot_cnt++;
      if ({fs_p, x_p, y_p} !== {1'b1, 4'd0, 4'd0})
         $display("FAIL en_rise: got %b want 100000000", {fs_p, x_p, y_p});
      else pass_cnt++;
   endtask

   task automatic test_pattern;
      logic [23:0] want;
      for (int i = 0; i < 128 && pos != 16; i++)
         step(1'b0, 1'b1);
      for (int h = 0; h < 16; h++) begin
         step(1'b0, 1'b1);
         want = (h < 8) ? bar_color(h) : 24'd0;
         tot_cnt++;
         if ({rgb_p, rgb_n} !== {want, want})
            $display("FAIL pattern h=%0d: got %h/%h want %h", h, rgb_p, rgb_n, want);
         else pass_cnt++;
      end
   endtask

   task automatic test_random;
      bit r, e;
      for (int i = 0; i < 800; i++) begin
         r = ($urandom_range(0, 63) == 0);
         e = ($urandom_range(0, 31) != 0);
         step(r, e);
         tot_cnt++;
         if ({obs_p, obs_n} !== {exp_p, exp_n})
            $display("FAIL random cyc %0d: got %h/%h want %h/%h", cyc, obs_p, obs_n, exp_p, exp_n);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset;
      test_frames;
      test_en_drop;
      test_pattern;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
